hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised RAW hazard unit for the in-order pipeline. Keeps a per-register
//  pending-write counter, so several in-flight writes to one register are tracked.
//  It shadows the E..WB stages with a DEPTH-entry {we,rd} tracking pipe.
//  It drives fetch/decode stall, decode/execute flush and back-end freeze, and
//  handles branch redirect and memory-busy.
// PARAMETERS
//  NREGS          32  architectural registers; register 0 is hardwired zero, never reserved
//  AW             5   register index width, = $clog2(NREGS)
//  DEPTH          3   tracked stages from E to WB inclusive (>=1)
//  WRITE_THROUGH  1   1: regfile is write-first, so a reg retiring this cycle reads as free
// PORTS
//  clk          in   1      clock, all state on rising edge
//  reset        in   1      asynchronous, active-high; clears all state
//  id_valid     in   1      decode holds a valid instruction
//  id_rs1       in   AW     decode source 1
//  id_rs2       in   AW     decode source 2
//  id_rs1_used  in   1      instruction reads rs1
//  id_rs2_used  in   1      instruction reads rs2
//  id_rd        in   AW     decode destination
//  id_reg_we    in   1      instruction writes rd
//  redirect     in   1      taken branch/jump resolved in E
//  mem_busy     in   1      memory stage cannot complete this cycle
//  stall_F      out  1      hold PC
//  stall_D      out  1      hold F/D register
//  flush_D      out  1      clear F/D register (bubble)
//  flush_E      out  1      clear D/E register (bubble)
//  stall_back   out  1      freeze D/E, E/M, M/WB registers
//  pending      out  NREGS  bit r = 1 while cnt[r] != 0 (debug/CSR)
// BEHAVIOUR
//  - State: cnt[r] (width CW = $clog2(DEPTH+1)), r=1..NREGS-1; pipe[0..DEPTH-1] = {v,rd}.
//  - Reset: all cnt=0, all pipe.v=0. Outputs are combinational; pending=0.
//    With id_valid=0, redirect=0 and mem_busy=0, all stall/flush outputs are 0.
//  - retire = pipe[DEPTH-1].v & ~mem_busy; ret_rd = pipe[DEPTH-1].rd.
//  - busy(r) = (r!=0) & (cnt[r]!=0) & ~(WRITE_THROUGH & retire & ret_rd==r & cnt[r]==1).
//  - hazard = id_valid & ((id_rs1_used & busy(id_rs1)) | (id_rs2_used & busy(id_rs2))).
//  - Priority of conditions: mem_busy > redirect > hazard.
//  - mem_busy=1 sets stall_F=stall_D=stall_back=1 and flush_D=flush_E=0.
//    The tracking pipe and all cnt are frozen: no issue, no retire.
//    redirect is ignored under mem_busy; its source holds it.
//  - redirect=1 (mem_busy=0) sets flush_D=flush_E=1 and stall_F=stall_D=0.
//    The decode instruction is killed and not issued.
//  - hazard=1 (no redirect, no mem_busy) sets stall_F=stall_D=1, flush_E=1, flush_D=0.
//  - issue = id_valid & id_reg_we & (id_rd!=0) & ~hazard & ~redirect & ~mem_busy.
//  - Each edge without mem_busy: pipe[0] <= {issue, id_rd}; pipe[i] <= pipe[i-1].
//  - cnt update: cnt[id_rd] += issue and cnt[ret_rd] -= retire.
//    If issue and retire hit the same register, cnt is unchanged.
//  - cnt never exceeds DEPTH and never underflows; the bench asserts both.
//  - Latency: producer issued at edge t. A dependent instruction in D stalls
//    DEPTH-1 cycles when WRITE_THROUGH=1 and DEPTH cycles when WRITE_THROUGH=0.
//  - Reset asserted mid-operation clears the scoreboard immediately (async).
//  - The first edge after reset release behaves as from an empty pipe.
// TESTING
//  - Reset, idle: id_valid=0 -> all outputs 0 and pending=0 for 10 cycles.
//  - Producer writes x5, then consumer reads rs1=x5 (DEPTH=3):
//    WT=1 -> stall_D high 2 cycles, flush_E high 2 cycles; WT=0 -> 3 cycles each.
//    The first uses ref bench setting WT=1; the last phrase is WT=0.
//  - Two writers to x7 back-to-back -> cnt[7] reaches 2 and pending[7]=1
//    until the second one retires; a reader of x7 stalls until then.
//  - Reads of x0 with a pending write to x0 -> never stall; pending[0]=0 always.
//  - redirect while a producer is in E -> flush_D=flush_E=1 and the killed D
//    writer is not reserved; the E producer still retires after DEPTH-1 edges.
//  - mem_busy held 4 cycles with x3 pending -> stall_back=1 and cnt[3] frozen;
//    on release x3 retires on schedule. Reset pulse mid-stall -> pending=0 at once.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   RAW hazard unit for the in-order pipeline. A per-register pending-write
//   counter allows several in-flight writes to the same register. A DEPTH-entry
//   {valid, rd} pipe shadows the E..WB stages so that the unit knows when each
//   write retires.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   id_valid                   decode holds a valid instruction
//   id_rs1/id_rs2              decode source registers
//   id_rs1_used/id_rs2_used    the instruction actually reads that source
//   id_rd, id_reg_we           decode destination and its write enable
//   redirect                   taken branch/jump resolved in E
//   mem_busy                   memory stage cannot complete this cycle
//   stall_F, stall_D           hold PC / hold F/D register
//   flush_D, flush_E           bubble into F/D / D/E register
//   stall_back                 freeze D/E, E/M, M/WB registers
//   pending                    bit r set while a write to r is in flight
module hazard_scoreboard #(
  parameter int unsigned NREGS         = 32,
  parameter int unsigned AW            = 5,
  parameter int unsigned DEPTH         = 3,
  parameter bit          WRITE_THROUGH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_reg_we,
  input  logic             redirect,
  input  logic             mem_busy,
  output logic             stall_F,
  output logic             stall_D,
  output logic             flush_D,
  output logic             flush_E,
  output logic             stall_back,
  output logic [NREGS-1:0] pending
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0] cnt     [NREGS];
  logic          pipe_v  [DEPTH];
  logic [AW-1:0] pipe_rd [DEPTH];

  logic             retire;
  logic [AW-1:0]    ret_rd;
  logic             busy1;
  logic             busy2;
  logic             hazard;
  logic             issue;
  logic [NREGS-1:1] inc_vec;
  logic [NREGS-1:1] dec_vec;

  // A register whose only outstanding write retires this cycle is readable
  // when the register file forwards the write to the read port.
  function automatic logic reg_busy(input logic [AW-1:0] r,
                                    input logic [CW-1:0] c,
                                    input logic          ret,
                                    input logic [AW-1:0] rr);
    return (r != '0) && (c != '0) &&
           !(WRITE_THROUGH && ret && (rr == r) && (c == CW'(1)));
  endfunction

  always_comb begin
    retire = pipe_v[DEPTH-1] & ~mem_busy;
    ret_rd = pipe_rd[DEPTH-1];
    busy1  = reg_busy(id_rs1, cnt[id_rs1], retire, ret_rd);
    busy2  = reg_busy(id_rs2, cnt[id_rs2], retire, ret_rd);
    hazard = id_valid & ((id_rs1_used & busy1) | (id_rs2_used & busy2));
    issue  = id_valid & id_reg_we & (id_rd != '0) & ~hazard & ~redirect & ~mem_busy;
  end

  // Priority: mem_busy over redirect over hazard.
  always_comb begin
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    flush_D    = 1'b0;
    flush_E    = 1'b0;
    stall_back = 1'b0;
    if (mem_busy) begin
      stall_F    = 1'b1;
      stall_D    = 1'b1;
      stall_back = 1'b1;
    end else if (redirect) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (hazard) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      inc_vec[r] = issue  & (id_rd  == AW'(r));
      dec_vec[r] = retire & (ret_rd == AW'(r));
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      pending[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt[r] <= '0;
      end
      for (int unsigned d = 0; d < DEPTH; d++) begin
        pipe_v[d]  <= 1'b0;
        pipe_rd[d] <= '0;
      end
    end else if (!mem_busy) begin
      pipe_v[0]  <= issue;
      pipe_rd[0] <= id_rd;
      for (int unsigned d = 1; d < DEPTH; d++) begin
        pipe_v[d]  <= pipe_v[d-1];
        pipe_rd[d] <= pipe_rd[d-1];
      end
      // Issue and retire to the same register cancel out.
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          cnt[r] <= cnt[r] + CW'(1);
        end else if (dec_vec[r] && !inc_vec[r]) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Drives a write-through and a non-write-through instance with identical
//   inputs. The reference model keeps a list of in-flight writes with their age
//   in edges since issue; a write retires during the cycle its age is DEPTH-1.
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_we, redirect, mem_busy;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0] s_F, s_D, f_D, f_E, s_B;
  logic [NREGS-1:0] pend0, pend1;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREGS(NREGS), .AW(AW), .DEPTH(DEPTH), .WRITE_THROUGH(1'b1)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .redirect(redirect), .mem_busy(mem_busy),
    .stall_F(s_F[0]), .stall_D(s_D[0]), .flush_D(f_D[0]), .flush_E(f_E[0]),
    .stall_back(s_B[0]), .pending(pend0));

  hazard_scoreboard #(.NREGS(NREGS), .AW(AW), .DEPTH(DEPTH), .WRITE_THROUGH(1'b0)) dut_nwt (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_we(id_reg_we), .redirect(redirect), .mem_busy(mem_busy),
    .stall_F(s_F[1]), .stall_D(s_D[1]), .flush_D(f_D[1]), .flush_E(f_E[1]),
    .stall_back(s_B[1]), .pending(pend1));

  typedef struct {
    int inst;
    int rd;
    int age;
  } wr_t;

  wr_t q[$];
  int total = 0;
  int bad   = 0;
  logic [1:0] samp_D, samp_E, samp_FD, samp_B;

  function automatic int m_count(input int inst, input int r);
    int n = 0;
    foreach (q[i]) if (q[i].inst == inst && q[i].rd == r) n++;
    return n;
  endfunction

  function automatic bit m_retiring(input int inst, input int r);
    foreach (q[i]) if (q[i].inst == inst && q[i].rd == r && q[i].age == DEPTH-1) return 1'b1;
    return 1'b0;
  endfunction

  // Instance 0 is write-through, instance 1 is not.
  function automatic bit m_busy(input int inst, input int r);
    int n;
    n = m_count(inst, r);
    if (r == 0 || n == 0) return 1'b0;
    if (inst == 0 && !mem_busy && n == 1 && m_retiring(inst, r)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_hazard(input int inst);
    return id_valid && ((id_rs1_used && m_busy(inst, int'(id_rs1))) ||
                        (id_rs2_used && m_busy(inst, int'(id_rs2))));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit hz;
    logic [NREGS-1:0] ep, op;
    logic [63:0] ec, oc;
    for (int k = 0; k < 2; k++) begin
      hz = m_hazard(k);
      ep = '0;
      ec = '0;
      oc = '0;
      for (int r = 0; r < NREGS; r++) begin
        ep[r] = (m_count(k, r) > 0);
        ec[r*2 +: 2] = 2'(m_count(k, r));
        oc[r*2 +: 2] = (k == 0) ? dut.cnt[r] : dut_nwt.cnt[r];
      end
      op = (k == 0) ? pend0 : pend1;
      chk($sformatf("stall_F[%0d]", k),    64'(s_F[k]), 64'(mem_busy || (!redirect && hz)));
      chk($sformatf("stall_D[%0d]", k),    64'(s_D[k]), 64'(mem_busy || (!redirect && hz)));
      chk($sformatf("flush_D[%0d]", k),    64'(f_D[k]), 64'(!mem_busy && redirect));
      chk($sformatf("flush_E[%0d]", k),    64'(f_E[k]), 64'(!mem_busy && (redirect || hz)));
      chk($sformatf("stall_back[%0d]", k), 64'(s_B[k]), 64'(mem_busy));
      chk($sformatf("pending[%0d]", k),    64'(op),     64'(ep));
      chk($sformatf("cnt[%0d]", k),        oc,          ec);
    end
    samp_D  = s_D;
    samp_E  = f_E;
    samp_FD = f_D;
    samp_B  = s_B;
  endtask

  task automatic model_update();
    bit iss [2];
    if (reset) begin
      q.delete();
      return;
    end
    if (mem_busy) return;
    for (int k = 0; k < 2; k++)
      iss[k] = id_valid && id_reg_we && (id_rd != 0) && !redirect && !m_hazard(k);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].age == DEPTH-1) q.delete(i);
    foreach (q[i]) q[i].age++;
    for (int k = 0; k < 2; k++)
      if (iss[k]) q.push_back('{inst: k, rd: int'(id_rd), age: 0});
  endtask

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic setin(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input bit rdr, input bit mb);
    id_valid    = v;
    id_rs1      = AW'(rs1);
    id_rs1_used = u1;
    id_rs2      = AW'(rs2);
    id_rs2_used = u2;
    id_rd       = AW'(rd);
    id_reg_we   = we;
    redirect    = rdr;
    mem_busy    = mb;
  endtask

  initial begin
    int n0, n1, e0, e1;

    // Reset and idle
    reset = 1'b1;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    q.delete();
    cyc();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("idle_pending", 64'(pend0 | pend1), 64'(0));

    // Producer x5 then consumer of x5
    setin(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc();
    setin(1, 5, 1, 0, 0, 0, 0, 0, 0);
    n0 = 0; n1 = 0; e0 = 0; e1 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n0 += int'(samp_D[0]); n1 += int'(samp_D[1]);
      e0 += int'(samp_E[0]); e1 += int'(samp_E[1]);
    end
    chk("lat_stallD_wt1", 64'(n0), 64'(2));
    chk("lat_stallD_wt0", 64'(n1), 64'(3));
    chk("lat_flushE_wt1", 64'(e0), 64'(2));
    chk("lat_flushE_wt0", 64'(e1), 64'(3));

    // Two back-to-back writers to x7, then a reader
    setin(1, 0, 0, 0, 0, 7, 1, 0, 0);
    cyc();
    cyc();
    chk("cnt7_two_wt1", 64'(dut.cnt[7]), 64'(2));
    chk("cnt7_two_wt0", 64'(dut_nwt.cnt[7]), 64'(2));
    chk("pend7", 64'(pend0[7]), 64'(1));
    setin(1, 7, 1, 7, 1, 0, 0, 0, 0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n0 += int'(samp_D[0]); n1 += int'(samp_D[1]);
    end
    chk("x7_stall_wt1", 64'(n0), 64'(2));
    chk("x7_stall_wt0", 64'(n1), 64'(3));
    chk("x7_released", 64'(pend0[7] | pend1[7]), 64'(0));

    // x0 is never reserved
    setin(1, 0, 1, 0, 1, 0, 1, 0, 0);
    n0 = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n0 += int'(samp_D[0]) + int'(samp_D[1]);
    end
    chk("x0_no_stall", 64'(n0), 64'(0));
    chk("x0_not_pending", 64'({pend0[0], pend1[0]}), 64'(0));

    // Redirect kills the decode writer; the E producer still retires
    setin(1, 0, 0, 0, 0, 9, 1, 0, 0);
    cyc();
    setin(1, 0, 0, 0, 0, 10, 1, 1, 0);
    cyc();
    chk("redir_flushD", 64'(samp_FD), 64'(2'b11));
    chk("redir_flushE", 64'(samp_E), 64'(2'b11));
    chk("redir_x10_free", 64'(pend0[10]), 64'(0));
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("redir_x9_live", 64'(pend0[9]), 64'(1));
    cyc();
    chk("redir_x9_retired", 64'(pend0[9]), 64'(0));

    // mem_busy freezes x3 for 4 cycles
    setin(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cyc();
    setin(1, 3, 1, 0, 0, 0, 0, 1, 1);
    n0 = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n0 += int'(samp_B[0]);
    end
    chk("mb_stall_back", 64'(n0), 64'(4));
    chk("mb_cnt3_frozen", 64'(dut.cnt[3]), 64'(1));
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("mb_x3_live", 64'(pend0[3]), 64'(1));
    cyc();
    chk("mb_x3_retired", 64'(pend0[3]), 64'(0));

    // Reset pulse in the middle of a memory stall
    setin(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cyc();
    setin(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc();
    reset = 1'b1;
    q.delete();
    #1;
    chk("rst_async_pend0", 64'(pend0), 64'(0));
    chk("rst_async_pend1", 64'(pend1), 64'(0));
    cyc();
    reset = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();

    // Random traffic on a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        q.delete();
        cyc();
        reset = 1'b0;
      end else begin
        setin($urandom_range(0, 9) < 8,
              int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
